// File: rtl/chrono_core.sv
// chrono_core: countdown timer / stopwatch with lap buffer; lap storage is built only with CHRONO_LAP_EN defined.
module chrono_core #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int MAX_MIN = 59,
  parameter int LAP_DEPTH = 4,
  localparam int MW = $clog2(MAX_MIN + 1),
  localparam int LW = $clog2(LAP_DEPTH),
  localparam int TW = $clog2(TICKS_PER_SEC)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          tick,
  input  logic          mode,
  input  logic          start,
  input  logic          stop,
  input  logic          clear,
  input  logic          inc_min,
  input  logic          inc_sec,
  input  logic          lap,
  input  logic          inc,
  input  logic [LW-1:0] lap_sel,
  output logic [MW-1:0] minutes,
  output logic [5:0]    seconds,
  output logic          running,
  output logic          blink,
  output logic          expired,
  output logic [MW-1:0] lap_minutes,
  output logic [5:0]    lap_seconds,
  output logic [LW:0]   lap_count
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;
  state_t        state_q, state_d;
  logic [MW-1:0] min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [TW-1:0] sub_q, sub_d;
  logic          mode_q, mode_d;
  logic [4:0]    btn_q, btn_d, edg;
  logic          lap_raw;
  logic          clr_e, stp_e, sta_e, imin_e, isec_e, step;
  logic [MW-1:0] min_up, min_dn;
  logic [5:0]    sec_up, sec_dn;
  assign btn_d  = {clear, stop, start, inc_min, inc_sec};
  assign edg    = btn_d & ~btn_q;
  // Only the highest-priority edge acts, even when that command is ignored in the current state.
  assign clr_e  = en & edg[4];
  assign stp_e  = en & edg[3] & ~edg[4];
  assign sta_e  = en & edg[2] & ~|edg[4:3];
  assign imin_e = en & edg[1] & ~|edg[4:2] & ~lap_raw;
  assign isec_e = en & edg[0] & ~|edg[4:1] & ~lap_raw;
  assign step   = en & tick & (state_q == RUN) & ~clr_e & ~stp_e;
  assign min_up = (min_q == MW'(MAX_MIN)) ? '0 : min_q + 1'b1;
  assign min_dn = (min_q == '0) ? MW'(MAX_MIN) : min_q - 1'b1;
  assign sec_up = (sec_q == 6'd59) ? 6'd0 : sec_q + 1'b1;
  assign sec_dn = (sec_q == 6'd0) ? 6'd59 : sec_q - 1'b1;
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    sub_d   = sub_q;
    mode_d  = mode_q;
    if (clr_e) begin
      state_d = IDLE;
      min_d   = '0;
      sec_d   = '0;
      sub_d   = '0;
    end else if (stp_e) begin
      state_d = (state_q == RUN) ? PAUSED : (state_q == EXPIRED) ? IDLE : state_q;
    end else if (sta_e) begin
      if (state_q == IDLE && (mode || min_q != '0 || sec_q != 6'd0)) begin
        state_d = RUN;
        mode_d  = mode;
        sub_d   = '0;
      end else if (state_q == PAUSED) begin
        state_d = RUN;
      end
    end else if ((imin_e || isec_e) && (state_q == IDLE || state_q == PAUSED)) begin
      min_d = imin_e ? (inc ? min_up : min_dn) : min_q;
      sec_d = isec_e ? (inc ? sec_up : sec_dn) : sec_q;
    end
    if (step) begin
      sub_d = (sub_q == TW'(TICKS_PER_SEC - 1)) ? '0 : sub_q + 1'b1;
      if (sub_q == TW'(TICKS_PER_SEC - 1)) begin
        if (!mode_q) begin
          // A step landing on (or starting from) 00:00 expires rather than underflowing.
          if (min_q == '0 && sec_q <= 6'd1) begin
            sec_d   = 6'd0;
            state_d = EXPIRED;
          end else begin
            sec_d = sec_dn;
            min_d = (sec_q == 6'd0) ? min_q - 1'b1 : min_q;
          end
        end else if (min_q == MW'(MAX_MIN) && sec_q == 6'd59) begin
          state_d = PAUSED;
        end else begin
          sec_d = sec_up;
          min_d = (sec_q == 6'd59) ? min_q + 1'b1 : min_q;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      sub_q   <= '0;
      mode_q  <= 1'b0;
      btn_q   <= '0;
    end else begin
      btn_q <= btn_d;
      if (en) begin
        state_q <= state_d;
        min_q   <= min_d;
        sec_q   <= sec_d;
        sub_q   <= sub_d;
        mode_q  <= mode_d;
      end
    end
  end
  assign minutes = min_q;
  assign seconds = sec_q;
  assign running = state_q == RUN;
  assign blink   = state_q == PAUSED || state_q == EXPIRED;
  assign expired = state_q == EXPIRED;
`ifdef CHRONO_LAP_EN
  logic          lap_q, lap_e;
  logic [MW+5:0] mem_q [LAP_DEPTH];
  logic [MW+5:0] mem_d [LAP_DEPTH];
  logic [LW-1:0] wr_q, wr_d, rd_idx;
  logic [LW:0]   cnt_q, cnt_d;
  logic [MW-1:0] lmin_q, lmin_d;
  logic [5:0]    lsec_q, lsec_d;
  assign lap_raw = lap & ~lap_q;
  assign lap_e   = en & lap_raw & ~|edg[4:2];
  // Newest entry sits just behind the write pointer.
  assign rd_idx  = wr_q - 1'b1 - lap_sel;
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    lmin_d = lmin_q;
    lsec_d = lsec_q;
    if (clr_e) begin
      wr_d  = '0;
      cnt_d = '0;
    end else if (lap_e && state_q == RUN && mode_q) begin
      mem_d[wr_q] = {min_q, sec_q};
      wr_d        = wr_q + 1'b1;
      cnt_d       = (cnt_q == (LW+1)'(LAP_DEPTH)) ? cnt_q : cnt_q + 1'b1;
    end
    if (en) {lmin_d, lsec_d} = ({1'b0, lap_sel} < cnt_q) ? mem_q[rd_idx] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q  <= 1'b0;
      wr_q   <= '0;
      cnt_q  <= '0;
      lmin_q <= '0;
      lsec_q <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      lap_q <= lap;
      if (en) begin
        wr_q   <= wr_d;
        cnt_q  <= cnt_d;
        lmin_q <= lmin_d;
        lsec_q <= lsec_d;
        mem_q  <= mem_d;
      end
    end
  end
  assign lap_minutes = lmin_q;
  assign lap_seconds = lsec_q;
  assign lap_count   = cnt_q;
`else
  logic unused_lap;
  assign lap_raw     = 1'b0;
  assign unused_lap  = ^{lap, lap_sel};
  assign lap_minutes = '0;
  assign lap_seconds = '0;
  assign lap_count   = '0;
`endif
endmodule
